// File: rtl/instr_ram_arbiter_if.sv
// Bus bundle between the arbiter and its three neighbours: the Wishbone slave port,
// the core instruction-fetch port and the single-port instruction SRAM macro.
interface instr_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  wbs_cyc_i;
  logic                  wbs_stb_i;
  logic                  wbs_we_i;
  logic [3:0]            wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [31:0]           wbs_dat_i;
  logic                  wbs_ack_o;
  logic [31:0]           wbs_dat_o;

  logic                  instr_req_i;
  logic [31:0]           instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;

  logic                  ram_csb_o;
  logic                  ram_web_o;
  logic [3:0]            ram_wmask_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_din_o;
  logic [31:0]           ram_dout_i;

  // Arbiter side
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o,
    input  ram_dout_i
  );

  // Environment side: Wishbone master, fetch unit and SRAM macro
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o,
    output ram_dout_i
  );
endinterface

// File: rtl/instr_ram_arbiter.sv
// Per-cycle arbiter sharing one single-port instruction SRAM between the Wishbone
// slave port and the core fetch port; round-robin on contention, 1-cycle read latency.
module instr_ram_arbiter #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  instr_ram_arbiter_if.slave bus
);

  localparam int TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    WB_ACK = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_last_wb;
  logic        r_wbs_ack;
  logic        r_wb_rd_pend;
  logic        r_instr_rvalid;
  logic [31:0] r_wbs_dat;

  logic        w_hit;
  logic        w_wb_access;
  logic        w_wb_req;
  logic        w_wb_oow;
  logic        w_core_req;
  logic        w_wb_grant;
  logic        w_core_grant;
  logic        w_wb_write;
  logic [3:0]  w_wmask;

  // Requests are gated by rstn_i so the SRAM is released the moment reset asserts.
  assign w_hit       = (bus.wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign w_wb_access = rstn_i & (r_state == ARB) & bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_wb_req    = w_wb_access & w_hit;
  assign w_wb_oow    = w_wb_access & ~w_hit;
  assign w_core_req  = rstn_i & bus.instr_req_i;

  // On contention the port that was not served last wins.
  assign w_wb_grant   = w_wb_req & (~w_core_req | ~r_last_wb);
  assign w_core_grant = w_core_req & ~w_wb_grant;
  assign w_wb_write   = w_wb_grant & bus.wbs_we_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign w_wmask[gi] = w_wb_write & bus.wbs_sel_i[gi];
    end
  endgenerate

  assign bus.ram_csb_o   = ~(w_wb_grant | w_core_grant);
  assign bus.ram_web_o   = ~w_wb_write;
  assign bus.ram_wmask_o = w_wmask;
  assign bus.ram_addr_o  = w_wb_grant ? bus.wbs_adr_i[TAG_LSB-1:2]
                                      : bus.instr_addr_i[TAG_LSB-1:2];
  assign bus.ram_din_o   = bus.wbs_dat_i;

  assign bus.instr_gnt_o    = w_core_grant;
  assign bus.instr_rvalid_o = r_instr_rvalid;
  assign bus.instr_rdata_o  = bus.ram_dout_i;

  // Read data arrives straight from the macro in the ack cycle, then is held.
  assign bus.wbs_ack_o = r_wbs_ack;
  assign bus.wbs_dat_o = r_wb_rd_pend ? bus.ram_dout_i : r_wbs_dat;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= ARB;
      r_last_wb      <= 1'b0;
      r_wbs_ack      <= 1'b0;
      r_wb_rd_pend   <= 1'b0;
      r_instr_rvalid <= 1'b0;
      r_wbs_dat      <= '0;
    end else begin
      r_instr_rvalid <= w_core_grant;
      r_wb_rd_pend   <= w_wb_grant & ~bus.wbs_we_i;

      if (r_wb_rd_pend) begin
        r_wbs_dat <= bus.ram_dout_i;
      end else if (w_wb_oow) begin
        r_wbs_dat <= '0;
      end

      // Out-of-window accesses never touch the round-robin pointer.
      if (w_wb_grant) begin
        r_last_wb <= 1'b1;
      end else if (w_core_grant) begin
        r_last_wb <= 1'b0;
      end

      case (r_state)
        ARB: begin
          if (w_wb_grant | w_wb_oow) begin
            r_state   <= WB_ACK;
            r_wbs_ack <= 1'b1;
          end else begin
            r_wbs_ack <= 1'b0;
          end
        end
        WB_ACK: begin
          r_state   <= ARB;
          r_wbs_ack <= 1'b0;
        end
        default: begin
          r_state   <= ARB;
          r_wbs_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run of both ports against
// a memory-image reference and per-port latency rules.
module tb_instr_ram_arbiter;

  localparam int          AW   = 9;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  instr_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  instr_ram_arbiter #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus)
  );

  logic [31:0] sram    [0:511];
  logic [31:0] ref_mem [0:511];
  int n_cmp = 0;
  int n_err = 0;

  // SRAM macro: masked write, 1-cycle registered read.
  always @(posedge clk_i) begin
    logic [31:0] nw;
    if (!bus.ram_csb_o) begin
      if (!bus.ram_web_o) begin
        nw = sram[bus.ram_addr_o];
        for (int b = 0; b < 4; b++)
          if (bus.ram_wmask_o[b]) nw[8*b +: 8] = bus.ram_din_o[8*b +: 8];
        sram[bus.ram_addr_o] = nw;
      end else begin
        bus.ram_dout_i <= sram[bus.ram_addr_o];
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i   = 1'b0;
    bus.wbs_stb_i   = 1'b0;
    bus.wbs_we_i    = 1'b0;
    bus.wbs_sel_i   = 4'h0;
    bus.instr_req_i = 1'b0;
  endtask

  task automatic ref_write(input int w, input logic [3:0] sel, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  // Single Wishbone transfer; returns ack latency in cycles (0 = no ack within 8).
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output int lat, output logic [31:0] rd);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = dat;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.wbs_ack_o) begin
        lat = i;
        rd  = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    $display("txn wb we=%0d adr=%h sel=%h wdat=%h rdat=%h lat=%0d", we, adr, sel, dat, rd, lat);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus.wbs_ack_o); end
    n_cmp++; if (bus.instr_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", bus.instr_rvalid_o); end
    n_cmp++; if (bus.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %h want 0", bus.wbs_dat_o); end
    n_cmp++; if (bus.ram_csb_o !== 1'b1) begin n_err++; $display("FAIL rst_csb: got %b want 1", bus.ram_csb_o); end
    n_cmp++; if (bus.ram_web_o !== 1'b1) begin n_err++; $display("FAIL rst_web: got %b want 1", bus.ram_web_o); end
    n_cmp++; if (bus.ram_wmask_o !== 4'h0) begin n_err++; $display("FAIL rst_wmask: got %h want 0", bus.ram_wmask_o); end
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE; bus.instr_req_i = 1'b1;
    #1;
    n_cmp++; if (bus.ram_csb_o !== 1'b1) begin n_err++; $display("FAIL rst_csb_req: got %b want 1", bus.ram_csb_o); end
    bus_idle();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_wb_write_read();
    int lat; logic [31:0] rd;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE + 32'h10; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.ram_csb_o !== 1'b0) begin n_err++; $display("FAIL wr_csb: got %b want 0", bus.ram_csb_o); end
    n_cmp++; if (bus.ram_web_o !== 1'b0) begin n_err++; $display("FAIL wr_web: got %b want 0", bus.ram_web_o); end
    n_cmp++; if (bus.ram_wmask_o !== 4'hF) begin n_err++; $display("FAIL wr_wmask: got %h want f", bus.ram_wmask_o); end
    n_cmp++; if (bus.ram_addr_o !== 9'd4) begin n_err++; $display("FAIL wr_addr: got %h want 4", bus.ram_addr_o); end
    n_cmp++; if (bus.ram_din_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_din: got %h want deadbeef", bus.ram_din_o); end
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", bus.wbs_ack_o); end
    bus_idle();
    ref_write(4, 4'hF, 32'hDEADBEEF);
    $display("txn wb write adr=%h dat=deadbeef", BASE + 32'h10);
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse: got %b want 0", bus.wbs_ack_o); end
    wb_access(1'b0, BASE + 32'h10, 4'hF, 32'h0, lat, rd);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rd_lat: got %0d want 1", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    tick();
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] rd;
    wb_access(1'b1, BASE + 32'h10, 4'b0010, 32'h0000AB00, lat, rd);
    ref_write(4, 4'b0010, 32'h0000AB00);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL mask_wr_lat: got %0d want 1", lat); end
    tick();
    wb_access(1'b0, BASE + 32'h12, 4'hF, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'hDEADABEF) begin n_err++; $display("FAIL mask_rd: got %h want deadabef", rd); end
    n_cmp++; if (rd !== ref_mem[4]) begin n_err++; $display("FAIL mask_ref: got %h want %h", rd, ref_mem[4]); end
    tick();
  endtask

  task automatic test_core_stream();
    for (int i = 0; i < 8; i++) begin
      bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'(i * 4);
      #1;
      n_cmp++; if (bus.instr_gnt_o !== 1'b1) begin n_err++; $display("FAIL stream_gnt[%0d]: got %b want 1", i, bus.instr_gnt_o); end
      tick();
      n_cmp++; if (bus.instr_rvalid_o !== 1'b1) begin n_err++; $display("FAIL stream_rvalid[%0d]: got %b want 1", i, bus.instr_rvalid_o); end
      n_cmp++; if (bus.instr_rdata_o !== ref_mem[i]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.instr_rdata_o, ref_mem[i]); end
      $display("txn fetch addr=%h data=%h", i * 4, bus.instr_rdata_o);
    end
    bus.instr_req_i = 1'b0;
    tick();
    n_cmp++; if (bus.instr_rvalid_o !== 1'b0) begin n_err++; $display("FAIL stream_end_rvalid: got %b want 0", bus.instr_rvalid_o); end
  endtask

  task automatic test_contention();
    int core_w = 16; logic pv = 1'b0; int pa = 0;
    int n_g = 0; int n_ack = 0; int wb_start = 0; int miss_run = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h8; bus.wbs_sel_i = 4'hF;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        n_cmp++; if (bus.instr_rvalid_o !== pv) begin n_err++; $display("FAIL cont_rvalid[%0d]: got %b want %b", c, bus.instr_rvalid_o, pv); end
        if (pv) begin
          n_cmp++; if (bus.instr_rdata_o !== ref_mem[pa]) begin n_err++; $display("FAIL cont_fetch[%0d]: got %h want %h", c, bus.instr_rdata_o, ref_mem[pa]); end
        end
        if (bus.wbs_ack_o === 1'b1) begin
          n_ack++;
          n_cmp++; if (c - wb_start > 2) begin n_err++; $display("FAIL cont_wb_lat: got %0d want <=2", c - wb_start); end
          n_cmp++; if (bus.wbs_dat_o !== ref_mem[2]) begin n_err++; $display("FAIL cont_wb_dat: got %h want %h", bus.wbs_dat_o, ref_mem[2]); end
          $display("txn wb read adr=%h data=%h lat=%0d", BASE + 32'h8, bus.wbs_dat_o, c - wb_start);
          wb_start = c + 1;
        end
      end
      if (c == 20) break;
      bus.instr_req_i = 1'b1;
      bus.instr_addr_i = 32'(core_w * 4);
      #1;
      pv = bus.instr_gnt_o;
      pa = core_w;
      if (bus.instr_gnt_o === 1'b1) begin n_g++; core_w++; miss_run = 0; end
      else miss_run++;
      n_cmp++; if (miss_run > 1) begin n_err++; $display("FAIL cont_core_gap[%0d]: got %0d idle want <=1", c, miss_run); end
      n_cmp++; if (bus.ram_csb_o !== 1'b0) begin n_err++; $display("FAIL cont_csb[%0d]: got %b want 0", c, bus.ram_csb_o); end
      tick();
    end
    bus_idle();
    n_cmp++; if (n_g !== 10) begin n_err++; $display("FAIL cont_core_share: got %0d want 10", n_g); end
    n_cmp++; if (n_ack !== 10) begin n_err++; $display("FAIL cont_wb_share: got %0d want 10", n_ack); end
    tick();
    n_cmp++; if (bus.instr_rvalid_o !== 1'b0 || bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL cont_drain: got rvalid=%b ack=%b want 0/0", bus.instr_rvalid_o, bus.wbs_ack_o); end
  endtask

  task automatic test_out_of_window();
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3100_0000;
    #1;
    n_cmp++; if (bus.ram_csb_o !== 1'b1) begin n_err++; $display("FAIL oow_csb: got %b want 1", bus.ram_csb_o); end
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL oow_ack: got %b want 1", bus.wbs_ack_o); end
    n_cmp++; if (bus.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL oow_dat: got %h want 0", bus.wbs_dat_o); end
    n_cmp++; if (bus.ram_csb_o !== 1'b1) begin n_err++; $display("FAIL oow_csb_ack: got %b want 1", bus.ram_csb_o); end
    $display("txn wb read adr=31000000 data=%h (out of window)", bus.wbs_dat_o);
    bus_idle();
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL oow_ack_pulse: got %b want 0", bus.wbs_ack_o); end
    // out-of-window write alongside a fetch: fetch still gets this cycle
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0820; bus.wbs_dat_i = 32'h1234_5678;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h20;
    #1;
    n_cmp++; if (bus.instr_gnt_o !== 1'b1) begin n_err++; $display("FAIL oow_core_gnt: got %b want 1", bus.instr_gnt_o); end
    n_cmp++; if (bus.ram_web_o !== 1'b1) begin n_err++; $display("FAIL oow_web: got %b want 1", bus.ram_web_o); end
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL oow_wr_ack: got %b want 1", bus.wbs_ack_o); end
    n_cmp++; if (bus.instr_rdata_o !== ref_mem[8]) begin n_err++; $display("FAIL oow_fetch: got %h want %h", bus.instr_rdata_o, ref_mem[8]); end
    bus_idle();
    tick();
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic [31:0] d = $urandom;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + 32'(300 * 4); bus.wbs_dat_i = d;
    tick();
    bus_idle();
    n_cmp++; if (bus.wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL abort_ack: got %b want 1", bus.wbs_ack_o); end
    ref_write(300, 4'hF, d);
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL abort_ack_once: got %b want 0", bus.wbs_ack_o); end
    wb_access(1'b0, BASE + 32'(300 * 4), 4'hF, 32'h0, lat, rd);
    n_cmp++; if (rd !== ref_mem[300]) begin n_err++; $display("FAIL abort_data: got %h want %h", rd, ref_mem[300]); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int lat; logic [31:0] rd;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = BASE + 32'h10;
    #1;
    n_cmp++; if (bus.ram_csb_o !== 1'b0) begin n_err++; $display("FAIL mrst_grant: got %b want 0", bus.ram_csb_o); end
    #2 rstn_i = 1'b0;
    #1;
    n_cmp++; if (bus.ram_csb_o !== 1'b1) begin n_err++; $display("FAIL mrst_csb: got %b want 1", bus.ram_csb_o); end
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL mrst_ack: got %b want 0", bus.wbs_ack_o); end
    n_cmp++; if (bus.instr_rvalid_o !== 1'b0) begin n_err++; $display("FAIL mrst_rvalid: got %b want 0", bus.instr_rvalid_o); end
    tick();
    n_cmp++; if (bus.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL mrst_ack_late: got %b want 0", bus.wbs_ack_o); end
    bus_idle();
    rstn_i = 1'b1;
    tick();
    wb_access(1'b0, BASE + 32'h10, 4'hF, 32'h0, lat, rd);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL mrst_post_lat: got %0d want 1", lat); end
    n_cmp++; if (rd !== ref_mem[4]) begin n_err++; $display("FAIL mrst_post_data: got %h want %h", rd, ref_mem[4]); end
    tick();
  endtask

  task automatic test_random();
    logic pv = 1'b0; int pa = 0; logic core_act = 1'b0; int core_w = 0; int core_wait = 0;
    logic wb_busy = 1'b0; logic wb_we = 1'b0; logic wb_oow = 1'b0; int wb_word = 0;
    logic [3:0] wb_sel = 4'h0; logic [31:0] wb_dat = '0; int wb_start = 0; logic just_acked;
    for (int c = 0; c <= 300; c++) begin
      just_acked = 1'b0;
      if (c > 0) begin
        n_cmp++; if (bus.instr_rvalid_o !== pv) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, bus.instr_rvalid_o, pv); end
        if (pv) begin
          n_cmp++; if (bus.instr_rdata_o !== ref_mem[pa]) begin n_err++; $display("FAIL rnd_fetch[%0d]: got %h want %h", c, bus.instr_rdata_o, ref_mem[pa]); end
        end
        if (bus.wbs_ack_o === 1'b1) begin
          n_cmp++; if (!wb_busy) begin n_err++; $display("FAIL rnd_ack_unexpected[%0d]: got ack=1 want 0", c); end
          if (wb_busy) begin
            if (wb_oow) begin
              n_cmp++; if (c - wb_start != 1 || bus.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL rnd_oow[%0d]: got lat=%0d dat=%h want 1/0", c, c - wb_start, bus.wbs_dat_o); end
            end else begin
              n_cmp++; if (c - wb_start > 2) begin n_err++; $display("FAIL rnd_wb_lat[%0d]: got %0d want <=2", c, c - wb_start); end
              if (wb_we) ref_write(wb_word, wb_sel, wb_dat);
              else begin
                n_cmp++; if (bus.wbs_dat_o !== ref_mem[wb_word]) begin n_err++; $display("FAIL rnd_wb_rd[%0d]: got %h want %h", c, bus.wbs_dat_o, ref_mem[wb_word]); end
              end
            end
            $display("txn wb we=%0d oow=%0d adr=%h sel=%h rdat=%h lat=%0d", wb_we, wb_oow, bus.wbs_adr_i, wb_sel, bus.wbs_dat_o, c - wb_start);
          end
          wb_busy = 1'b0; just_acked = 1'b1;
          bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        end else if (wb_busy) begin
          n_cmp++;
          if (c - wb_start > (wb_oow ? 0 : 1)) begin
            n_err++; $display("FAIL rnd_wb_timeout[%0d]: got no ack after %0d want ack", c, c - wb_start);
            wb_busy = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
          end
        end
      end
      if (c == 300) break;
      if (!wb_busy && !just_acked && $urandom_range(0, 2) == 0) begin
        wb_oow = ($urandom_range(0, 4) == 0);
        wb_we  = $urandom_range(0, 1) == 1;
        wb_word = wb_we ? 256 + $urandom_range(0, 255) : $urandom_range(0, 511);
        wb_sel = 4'($urandom_range(1, 15));
        wb_dat = $urandom;
        bus.wbs_adr_i = wb_oow ? (($urandom_range(0, 1) == 1 ? 32'h3000_0800 : 32'h7000_0000) + 32'($urandom_range(0, 2047)))
                               : BASE + 32'(wb_word * 4) + 32'($urandom_range(0, 3));
        bus.wbs_we_i = wb_we; bus.wbs_sel_i = wb_sel; bus.wbs_dat_i = wb_dat;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        wb_busy = 1'b1; wb_start = c;
      end
      if (!core_act && $urandom_range(0, 3) != 0) begin
        core_act = 1'b1; core_w = $urandom_range(0, 255);
      end
      bus.instr_req_i = core_act;
      bus.instr_addr_i = 32'(core_w * 4);
      #1;
      pv = bus.instr_gnt_o; pa = core_w;
      if (!core_act) begin
        n_cmp++; if (bus.instr_gnt_o !== 1'b0) begin n_err++; $display("FAIL rnd_gnt_idle[%0d]: got %b want 0", c, bus.instr_gnt_o); end
      end else if (bus.instr_gnt_o === 1'b1) begin
        core_wait = 0;
        core_act = ($urandom_range(0, 3) != 0);
        core_w = $urandom_range(0, 255);
      end else begin
        core_wait++;
        n_cmp++; if (core_wait > 1) begin n_err++; $display("FAIL rnd_core_starve[%0d]: got wait %0d want <=1", c, core_wait); end
      end
      tick();
    end
    bus_idle();
    tick();
  endtask

  initial begin
    rstn_i = 1'b1;
    bus_idle();
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.instr_addr_i = '0;
    for (int i = 0; i < 512; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[2] = 32'hCAFE_0002;
    ref_mem[2] = 32'hCAFE_0002;
    #1 rstn_i = 1'b0;
    test_reset();
    test_wb_write_read();
    test_byte_mask();
    test_core_stream();
    test_contention();
    test_out_of_window();
    test_abort();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
